// File: rtl/uart_pkg.sv
// uart_pkg: header bytes shared with the receiver, packet FSM state encoding and baud divisor.
package uart_pkg;

    localparam logic [7:0] UART_HDR0 = 8'hAA;
    localparam logic [7:0] UART_HDR1 = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } tx_state_t;

    function automatic int baud_div(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serialiser; a start request on the last stop-bit cycle chains the
// next byte with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = baud_div(50_000_000, 115200)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_byte_start,
    input  logic [7:0] i_byte_data,
    output logic       o_byte_done,
    output logic       o_txd
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          w_bit_end;

    assign w_bit_end   = r_active && r_cnt == LAST;
    assign o_byte_done = w_bit_end && r_bit == 4'd9;

    // Shifter carries a leading 1 so the stop bit falls out after the eight data bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            o_txd    <= 1'b1;
        end else if (i_byte_start && (!r_active || o_byte_done)) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= {1'b1, i_byte_data};
            o_txd    <= 1'b0;
        end else if (w_bit_end) begin
            r_cnt    <= '0;
            r_bit    <= r_bit == 4'd9 ? 4'd0 : r_bit + 4'd1;
            r_active <= r_bit != 4'd9;
            r_shift  <= r_shift >> 1;
            o_txd    <= r_shift[0] | (r_bit == 4'd9);
        end else if (r_active) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// uart_mult_byte_tx: framed packet transmitter (AA 55 len payload [checksum]).
// Define UART_TX_CHECKSUM_EN to append the (len + payload) mod 256 checksum byte.
module uart_mult_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int MAX_BYTES = 12
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   tx_start,
    input  logic [3:0]             tx_len,
    input  logic [8*MAX_BYTES-1:0] tx_payload,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_err,
    output logic                   uart_txd
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, UART_BPS);
    localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);
`ifdef UART_TX_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    tx_state_t              r_state;
    logic [3:0]             r_len;
    logic [3:0]             r_idx;
    logic [8*MAX_BYTES-1:0] r_payload;
    logic                   w_legal;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_byte_done;
    logic                   w_byte_start;
    logic [7:0]             w_byte_data;
    logic [7:0]             w_tail;

`ifdef UART_TX_CHECKSUM_EN
    logic [7:0] r_csum;
    assign w_tail = r_csum + r_payload[7:0];
`else
    assign w_tail = '0;
`endif

    assign w_legal  = tx_len != 4'd0 && tx_len <= MAX_LEN;
    assign w_accept = r_state == ST_IDLE && tx_start && w_legal;
    assign w_last   = r_idx == r_len - 4'd1;

    // The current payload byte always sits in r_payload[7:0]; the next one in [15:8].
    assign w_byte_start = w_accept || (w_byte_done &&
        (r_state inside {ST_HDR0, ST_HDR1, ST_LEN} || (r_state == ST_DATA && (!w_last || CSUM_EN))));
    assign w_byte_data = r_state == ST_IDLE ? UART_HDR0 :
                         r_state == ST_HDR0 ? UART_HDR1 :
                         r_state == ST_HDR1 ? {4'd0, r_len} :
                         r_state == ST_LEN  ? r_payload[7:0] :
                         w_last             ? w_tail : r_payload[15:8];

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .i_clk       (sys_clk),
        .i_rst_n     (sys_rst_n),
        .i_byte_start(w_byte_start),
        .i_byte_data (w_byte_data),
        .o_byte_done (w_byte_done),
        .o_txd       (uart_txd)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_idx     <= '0;
            r_payload <= '0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (r_state)
                ST_IDLE: if (tx_start) begin
                    if (w_legal) begin
                        r_state   <= ST_HDR0;
                        r_len     <= tx_len;
                        r_idx     <= '0;
                        r_payload <= tx_payload;
                        tx_busy   <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
                        r_csum    <= {4'd0, tx_len};
`endif
                    end else begin
                        tx_err <= 1'b1;
                    end
                end
                ST_HDR0: if (w_byte_done) r_state <= ST_HDR1;
                ST_HDR1: if (w_byte_done) r_state <= ST_LEN;
                ST_LEN:  if (w_byte_done) r_state <= ST_DATA;
                ST_DATA: if (w_byte_done) begin
                    r_payload <= r_payload >> 8;
                    r_idx     <= r_idx + 4'd1;
`ifdef UART_TX_CHECKSUM_EN
                    r_csum    <= w_tail;
                    if (w_last) r_state <= ST_CSUM;
`else
                    if (w_last) begin
                        r_state <= ST_DONE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
`endif
                end
`ifdef UART_TX_CHECKSUM_EN
                ST_CSUM: if (w_byte_done) begin
                    r_state <= ST_DONE;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_mult_byte_tx.md
Name: uart_mult_byte_tx

Overview:
Multi-byte UART packet transmitter, the transmit-side counterpart of the packet receiver, driving the top-level uart_txd pin.
- Serialises one framed packet: fixed 2-byte header, length byte, 1..12 payload bytes, optional checksum byte.
- Used to return register readback, acknowledgements and PWM busy/valid status to the host.
- Runs in the 50 MHz system domain alongside the receiver and the register mapper.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BAUD_DIV = CLK_FREQ/UART_BPS (integer division, 434 at defaults)
MAX_BYTES, 12, maximum payload bytes per packet

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous active-low reset
tx_start  input  1  one-cycle request to send a packet
tx_len  input  4  payload byte count; legal range 1..MAX_BYTES
tx_payload  input  8*MAX_BYTES  payload; byte k = tx_payload[8k+7:8k], byte 0 sent first
tx_busy  output  1  packet in progress
tx_done  output  1  one-cycle pulse when the packet is complete
tx_err  output  1  one-cycle pulse when tx_start is rejected for an illegal length
uart_txd  output  1  serial line, idle high

Behaviour:
- Reset values (asynchronous, immediate): uart_txd=1, tx_busy=0, tx_done=0, tx_err=0, FSM=IDLE, all counters 0.
- Byte format: 8N1, LSB first. Each bit is held exactly BAUD_DIV cycles. No idle gap between bytes: the next start bit follows the previous stop bit directly.
- Frame order: 0xAA, 0x55, tx_len, payload[0..tx_len-1], then checksum if enabled (see Optional Feature).
- Accept rule: tx_start is sampled only in IDLE. If 1<=tx_len<=MAX_BYTES, the block latches tx_len and tx_payload in that cycle. Inputs may change afterwards without affecting the packet.
- Latency: on the cycle after accept, tx_busy=1 and uart_txd=0 (start bit of 0xAA).
- Illegal length: tx_len=0 or tx_len>MAX_BYTES in IDLE gives tx_err=1 on the next cycle. The FSM stays in IDLE and uart_txd stays high.
- tx_start while busy: ignored, no error, no queueing.
- FSM states and transitions:
  - IDLE -> HDR0 on a legal start.
  - HDR0 -> HDR1 -> LEN -> DATA.
  - DATA loops with byte_idx 0..tx_len-1.
  - DATA -> CSUM if the feature is enabled, otherwise DATA -> DONE.
  - CSUM -> DONE.
  - DONE -> IDLE after one cycle.
- State advances on the last cycle of each stop bit.
- Completion: in DONE, tx_done=1 for one cycle and tx_busy falls in the same cycle. uart_txd is high. A new tx_start is accepted the following cycle.
- Reset mid-packet: the frame is aborted, uart_txd returns high immediately, and no tx_done is issued.
- Width rules: baud counter is clog2(BAUD_DIV) bits, bit index 4 bits (0..9), byte_idx 4 bits. Checksum arithmetic is 8-bit wrap-around.

Optional Feature:
Macro UART_TX_CHECKSUM_EN.
- Defined: after the payload, send one byte equal to (tx_len + sum of payload bytes) mod 256. The frame is tx_len+4 bytes. The checksum accumulates during DATA, with no extra latency.
- Undefined: CSUM state and accumulator are not built, DATA goes straight to DONE, and the frame is tx_len+3 bytes.

Decomposition:
- Shared package uart_pkg holds:
  - header constants UART_HDR0=8'hAA and UART_HDR1=8'h55, which the receiver also uses;
  - the state-encoding typedef;
  - the BAUD_DIV computation.
- One sub-module, uart_byte_tx:
  - handshake byte_start/byte_data in, byte_done out, serial line out;
  - contains the baud counter and bit shifter.
- The parent FSM only sequences bytes and counts.

Test Plan:
- Checksum enabled, tx_len=1, payload byte0=0x3C -> decoded bytes AA 55 01 3C 3D; tx_done at cycle 1+5*10*434=21701 after accept; tx_busy high throughout.
- Checksum enabled, tx_len=12, bytes 0x01..0x0C -> 16 bytes sent; checksum 0x0C+0x4E=0x5A; no inter-byte gap, every bit exactly 434 cycles.
- tx_len=0, then tx_len=13 -> tx_err pulses once each; uart_txd stays 1; tx_busy stays 0.
- tx_start re-pulsed mid-packet with different payload -> ignored; original frame is unchanged; exactly one tx_done.
- sys_rst_n asserted during payload byte 2 -> uart_txd=1 and tx_busy=0 with no clock edge; after release, a fresh tx_len=2 packet AA 55 02 xx yy cs is correct.
- Checksum macro undefined, tx_len=1, 0x3C -> bytes AA 55 01 3C only; tx_done at 1+4*10*434=17361 cycles.
